// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states and digit selects.
package booth_pkg;

  // Control states of the multiplier sequencer
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Booth digit selects produced from one 3-bit multiplier window
  typedef enum logic [2:0] {
    ZERO = 3'd0,
    PX   = 3'd1,
    P2X  = 3'd2,
    MX   = 3'd3,
    M2X  = 3'd4
  } digit_e;

endpackage

// File: rtl/radix4_booth_mult_param_if.sv
// Operand/product handshake bundle for the radix-4 Booth multiplier.
interface radix4_booth_mult_param_if #(
  parameter int WIDTH = 32
);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     x;
  logic [WIDTH-1:0]     y;
  logic                 is_signed;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out;
  logic                 busy;

  // Producer/consumer side: offers operands, accepts products
  modport master (
    output in_valid, x, y, is_signed, out_ready,
    input  in_ready, out_valid, out, busy
  );

  // Multiplier side
  modport slave (
    input  in_valid, x, y, is_signed, out_ready,
    output in_ready, out_valid, out, busy
  );

endinterface

// File: rtl/booth_digit_enc.sv
// Radix-4 Booth recoder: maps {y[2i+1], y[2i], y[2i-1]} to a digit select.
module booth_digit_enc
  import booth_pkg::*;
(
  input  logic [2:0] window_i,
  output digit_e     digit_o
);

  // Pure lookup of the Booth digit for the current multiplier window
  always_comb begin
    digit_o = ZERO;
    case (window_i)
      3'b001, 3'b010: digit_o = PX;
      3'b011:         digit_o = P2X;
      3'b100:         digit_o = M2X;
      3'b101, 3'b110: digit_o = MX;
      default:        digit_o = ZERO;
    endcase
  end

endmodule

// File: rtl/radix4_booth_mult_param.sv
// Sequential radix-4 Booth multiplier: one Booth digit per cycle through a
// single WIDTH+3 bit adder/subtractor, with the multiplier shifting out of the
// low half of a combined {accumulator, multiplier} shift register.
module radix4_booth_mult_param
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic                      clk,
  input logic                      reset,
  radix4_booth_mult_param_if.slave bus
);

  // Extended operand width, adder width, digit count and counter width
  localparam int XW   = WIDTH + 2;
  localparam int AW   = WIDTH + 3;
  localparam int NDIG = WIDTH / 2 + 1;
  localparam int CW   = $clog2(NDIG + 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   hi_q, hi_d;
  logic [XW-1:0]   lo_q, lo_d;
  logic            prev_q, prev_d;
  logic [XW-1:0]   mcand_q, mcand_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  digit_e          digit;
  logic [AW-1:0]   mag;
  logic [AW-1:0]   addend;
  logic [AW-1:0]   sum;
  logic            sub;

  booth_digit_enc u_digit_enc (
    .window_i ({lo_q[1:0], prev_q}),
    .digit_o  (digit)
  );

  // Single adder/subtractor: negative digits add the inverted magnitude plus one
  always_comb begin
    mag = '0;
    sub = 1'b0;
    case (digit)
      PX:      mag = {mcand_q[XW-1], mcand_q};
      P2X:     mag = {mcand_q, 1'b0};
      MX: begin
        mag = {mcand_q[XW-1], mcand_q};
        sub = 1'b1;
      end
      M2X: begin
        mag = {mcand_q, 1'b0};
        sub = 1'b1;
      end
      default: mag = '0;
    endcase
    addend = sub ? ~mag : mag;
    sum    = hi_q + addend + {{(AW-1){1'b0}}, sub};
  end

  // Sequencer and datapath next-state: capture, per-digit accumulate/shift, hold
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    prev_d  = prev_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          mcand_d = bus.is_signed ? {{2{bus.x[WIDTH-1]}}, bus.x} : {2'b00, bus.x};
          lo_d    = bus.is_signed ? {{2{bus.y[WIDTH-1]}}, bus.y} : {2'b00, bus.y};
          hi_d    = '0;
          prev_d  = 1'b0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        hi_d   = {{2{sum[AW-1]}}, sum[AW-1:2]};
        lo_d   = {sum[1:0], lo_q[XW-1:2]};
        prev_d = lo_q[1];
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(NDIG - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared immediately by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      prev_q  <= 1'b0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      prev_q  <= prev_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake flags decode the state; the product is the low 2*WIDTH bits
  // of the {accumulator, multiplier} register pair
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.busy      = (state_q == CALC);
    bus.out_valid = (state_q == DONE);
    bus.out       = {hi_q[WIDTH-3:0], lo_q};
  end

endmodule

// File: doc/radix4_booth_mult_param.md
RADIX4_BOOTH_MULT_PARAM -- requirements
Module: radix4_booth_mult_param

Interface
REQ-001 Parameter WIDTH, default 32: operand width; SHALL be even and >= 4.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; reset=0 immediately clears all state.
REQ-004 in_valid  input  1  operand pair x/y/is_signed offered.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 x  input  WIDTH  multiplicand.
REQ-007 y  input  WIDTH  multiplier.
REQ-008 is_signed  input  1  1 = two's-complement operands, 0 = unsigned operands.
REQ-009 out_valid  output  1  product holds a completed result.
REQ-010 out_ready  input  1  consumer accepts the product.
REQ-011 out  output  2*WIDTH  product, held stable while out_valid=1.
REQ-012 busy  output  1  high while in state CALC.

Function
REQ-013 FSM states IDLE, CALC, DONE; in_ready=1 only in IDLE; busy=1 only in CALC; out_valid=1 only in DONE.
REQ-014 IDLE & in_valid=1 -> capture x, y, is_signed; go to CALC; digit counter=0; accumulator=0.
REQ-015 Operands are internally extended to WIDTH+2 bits: sign-extended if is_signed=1, zero-extended otherwise.
REQ-016 CALC retires one radix-4 Booth digit per cycle, LSB digit first, using multiplier bits {y[2i+1], y[2i], y[2i-1]} with y[-1]=0.
REQ-017 Digit recoding: 000/111->0, 001/010->+X, 011->+2X, 100->-2X, 101/110->-X; -X and -2X formed by two's complement at WIDTH+3 bits.
REQ-018 CALC runs exactly WIDTH/2+1 digits, then moves to DONE; out_valid rises WIDTH/2+1 cycles after the accepting edge (17 for WIDTH=32), independent of operand values.
REQ-019 out = low 2*WIDTH bits of the exact product; signed mode gives the two's-complement product, unsigned mode the unsigned product; no overflow possible.
REQ-020 DONE & out_ready=1 -> IDLE at that edge; out_valid drops next cycle; new operands not accepted in the same cycle.
REQ-021 DONE & out_ready=0 -> remain in DONE indefinitely, out unchanged.
REQ-022 in_valid during CALC or DONE is ignored; operand pins may change after acceptance without affecting the result.
REQ-023 out_ready outside DONE has no effect.

Reset
REQ-024 reset=0 in any state (including mid-CALC) -> state IDLE, counter 0, accumulator 0, out=0, out_valid=0, busy=0, in_ready=1; partial result discarded.
REQ-025 First operand accepted on the first rising edge with reset=1 and in_valid=1.

Structure
REQ-026 Shared package booth_pkg holds the FSM state enum and the Booth digit-select enum (ZERO, PX, P2X, MX, M2X).
REQ-027 Sub-module booth_digit_enc: combinational 3-bit window -> digit-select enum; instantiated once.
REQ-028 Single adder/subtractor of WIDTH+3 bits plus a shift register for multiplier and accumulator; no array of partial products.

Verification
REQ-029 WIDTH=32, signed, x=0x00087234, y=0x00000348 -> out=0x000000001BB6BAA0, out_valid after 17 cycles.
REQ-030 Signed x=0xFFFFFEFD, y=0x00087234 -> 0xFFFFFFFFF7747564; same operands unsigned -> 0x00087233F7747564.
REQ-031 Signed x=y=0x80000000 -> 0x4000000000000000; unsigned x=y=0xFFFFFFFF -> 0xFFFFFFFE00000001; x=0 or y=0 -> 0.
REQ-032 out_ready held 0 for 10 cycles in DONE -> out stable, in_ready=0, in_valid pulses ignored; release -> IDLE next edge.
REQ-033 reset=0 asserted mid-CALC (cycle 8) -> outputs at reset values immediately; next operands 0x1 * 0xB887CAAF signed -> 0xFFFFFFFFB887CAAF.
REQ-034 WIDTH=8 randomized 1000 signed/unsigned pairs vs reference model; latency exactly 5 cycles each.
